// File: rtl/sobel_frame_engine.sv
// Streams one stored frame in raster order through two line buffers and a 3x3 window,
// writing one Sobel edge-magnitude RGB565 pixel per image pixel (borders forced to zero).
module sobel_frame_engine #(
   parameter int IM_WIDTH  = 320,
   parameter int IM_LENGTH = 280,
   parameter int THRESH    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [16:0] src_addr,
   output logic        src_rd,
   input  logic [15:0] src_data,
   output logic        wr_en,
   output logic [16:0] wr_addr,
   output logic [15:0] wr_data
);

   localparam int XW = $clog2(IM_WIDTH + 1);
   localparam int YW = $clog2(IM_LENGTH + 1);
   localparam logic [10:0] THR = 11'(THRESH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    flush_cnt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          x_end, y_end;

   assign x_end    = (x == XW'(IM_WIDTH));
   assign y_end    = (y == YW'(IM_LENGTH));
   assign src_rd   = (state == S_RUN) && !x_end && !y_end;
   assign src_addr = 17'(y) * 17'(IM_WIDTH) + 17'(x);
   assign busy     = (state == S_RUN) || (state == S_FLUSH);
   assign done     = (state == S_DONE);

   // Scan counter is cleared on leaving RUN so the address idles at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         flush_cnt <= '0;
         x         <= '0;
         y         <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               x     <= '0;
               y     <= '0;
               state <= S_RUN;
            end
            S_RUN: if (x_end && y_end) begin
               state     <= S_FLUSH;
               flush_cnt <= '0;
               x         <= '0;
               y         <= '0;
            end else if (x_end) begin
               x <= '0;
               y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
            S_FLUSH: if (flush_cnt == 2'd2) state <= S_DONE;
                     else flush_cnt <= flush_cnt + 2'd1;
            default: state <= S_IDLE;
         endcase
      end
   end

   logic          s1_vld, s1_rd;
   logic [XW-1:0] s1_x;
   logic [YW-1:0] s1_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_rd  <= 1'b0;
         s1_x   <= '0;
         s1_y   <= '0;
      end else begin
         s1_vld <= (state == S_RUN);
         s1_rd  <= src_rd;
         s1_x   <= x;
         s1_y   <= y;
      end
   end

   logic [7:0] src_unused;
   logic [7:0] pix_in;
   assign src_unused = src_data[15:8];
   assign pix_in     = s1_rd ? src_data[7:0] : 8'd0;

   // lb0 holds row y-2, lb1 holds row y-1, indexed by scan column.
   logic [7:0] lb0 [IM_WIDTH+1];
   logic [7:0] lb1 [IM_WIDTH+1];

   always_ff @(posedge clk) begin
      if (s1_vld) begin
         lb0[s1_x] <= lb1[s1_x];
         lb1[s1_x] <= pix_in;
      end
   end

   logic [7:0]    p [3][3];
   logic          s2_vld;
   logic [XW-1:0] s2_x;
   logic [YW-1:0] s2_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               p[r][c] <= '0;
         s2_vld <= 1'b0;
         s2_x   <= '0;
         s2_y   <= '0;
      end else begin
         if (s1_vld) begin
            for (int r = 0; r < 3; r++) begin
               p[r][0] <= p[r][1];
               p[r][1] <= p[r][2];
            end
            p[0][2] <= lb0[s1_x];
            p[1][2] <= lb1[s1_x];
            p[2][2] <= pix_in;
         end
         s2_vld <= s1_vld;
         s2_x   <= s1_x;
         s2_y   <= s1_y;
      end
   end

   logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
   logic [10:0] gx, gy, ax, ay, mag;
   logic [7:0]  m;
   logic [1:0]  m_unused;
   logic        border, wr_hit;

   always_comb begin
      gx_pos = {3'b0, p[0][2]} + {2'b0, p[1][2], 1'b0} + {3'b0, p[2][2]};
      gx_neg = {3'b0, p[0][0]} + {2'b0, p[1][0], 1'b0} + {3'b0, p[2][0]};
      gy_pos = {3'b0, p[2][0]} + {2'b0, p[2][1], 1'b0} + {3'b0, p[2][2]};
      gy_neg = {3'b0, p[0][0]} + {2'b0, p[0][1], 1'b0} + {3'b0, p[0][2]};
      gx     = gx_pos - gx_neg;
      gy     = gy_pos - gy_neg;
      ax     = gx[10] ? (~gx + 11'd1) : gx;
      ay     = gy[10] ? (~gy + 11'd1) : gy;
      mag    = ax + ay;
      m      = (mag > 11'd255) ? 8'hFF : mag[7:0];
      if (THRESH > 0) m = (mag >= THR) ? 8'hFF : 8'h00;
   end

   assign m_unused = m[1:0];
   // Scan position (x,y) writes centre (x-1,y-1); border centres map to x==1, y==1, x==W, y==L.
   assign wr_hit = s2_vld && (s2_x != '0) && (s2_y != '0);
   assign border = (s2_x == XW'(1)) || (s2_y == YW'(1)) ||
                   (s2_x == XW'(IM_WIDTH)) || (s2_y == YW'(IM_LENGTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= wr_hit;
         if (wr_hit) begin
            wr_addr <= 17'(s2_y - YW'(1)) * 17'(IM_WIDTH) + 17'(s2_x - XW'(1));
            wr_data <= border ? 16'h0000 : {m[7:3], m[7:2], m[7:3]};
         end
      end
   end

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Randomised and directed frames through two engines (grayscale and thresholded),
// compared pixel-by-pixel against a direct Sobel model of the source image.
module tb_sobel_frame_engine;

   localparam int W    = 12;
   localparam int L    = 10;
   localparam int N    = (W + 1) * (L + 1);
   localparam int NPIX = W * L;
   localparam int THR1 = 40;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] src_data;
   logic        busy0, done0, src_rd0, wr_en0;
   logic        busy1, done1, src_rd1, wr_en1;
   logic [16:0] src_addr0, wr_addr0, src_addr1, wr_addr1;
   logic [15:0] wr_data0, wr_data1;

   always #5 clk = ~clk;

   sobel_frame_engine #(.IM_WIDTH(W), .IM_LENGTH(L), .THRESH(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
      .src_addr(src_addr0), .src_rd(src_rd0), .src_data(src_data),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

   sobel_frame_engine #(.IM_WIDTH(W), .IM_LENGTH(L), .THRESH(THR1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
      .src_addr(src_addr1), .src_rd(src_rd1), .src_data(src_data),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

   int          img [NPIX];
   logic [15:0] res0 [NPIX];
   logic [15:0] res1 [NPIX];
   int          wcnt0, wcnt1, order_err, done_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Source RAM: one-cycle read latency, junk in the upper byte.
   always @(posedge clk) begin
      if (src_rd0 && src_addr0 < NPIX)
         src_data <= {8'($urandom), 8'(img[src_addr0])};
      else
         src_data <= 16'($urandom);
   end

   always @(negedge clk) begin
      if (wr_en0 === 1'b1) begin
         if (wr_addr0 != 17'(wcnt0)) order_err++;
         if (wr_addr0 < NPIX) res0[wr_addr0] = wr_data0;
         wcnt0++;
      end
      if (wr_en1 === 1'b1) begin
         if (wr_addr1 < NPIX) res1[wr_addr1] = wr_data1;
         wcnt1++;
      end
      if (done0 === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pix(input int x, input int y);
      if (x < 0 || x >= W || y < 0 || y >= L) return 0;
      return img[y * W + x];
   endfunction

   function automatic logic [15:0] ref_pix(input int cx, input int cy, input int thr);
      int gx, gy, mag, m;
      logic [7:0] mb;
      if (cx == 0 || cy == 0 || cx == W - 1 || cy == L - 1) return 16'h0000;
      gx = 0;
      gy = 0;
      for (int d = -1; d <= 1; d++) begin
         int wt;
         wt = (d == 0) ? 2 : 1;
         gx += wt * (pix(cx + 1, cy + d) - pix(cx - 1, cy + d));
         gy += wt * (pix(cx + d, cy + 1) - pix(cx + d, cy - 1));
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      m   = (mag > 255) ? 255 : mag;
      if (thr > 0) m = (mag >= thr) ? 255 : 0;
      mb = 8'(m);
      return {mb[7:3], mb[7:2], mb[7:3]};
   endfunction

   task automatic fill(input int mode, input int val);
      for (int i = 0; i < NPIX; i++) begin
         case (mode)
            0:       img[i] = int'($urandom_range(0, 255));
            1:       img[i] = 77;
            2:       img[i] = ((i % W) >= W / 2) ? 255 : 0;
            default: img[i] = (i == (L / 2) * W + W / 2) ? val : 0;
         endcase
      end
   endtask

   task automatic clear_capture();
      wcnt0 = 0;
      wcnt1 = 0;
      order_err = 0;
      done_cnt = 0;
      for (int i = 0; i < NPIX; i++) begin
         res0[i] = 16'hDEAD;
         res1[i] = 16'hDEAD;
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start at edge 0, optionally re-pulse start while busy, and compare the whole frame.
   task automatic run_frame(input string name, input int restart_at);
      int cyc;
      clear_capture();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 1;
      check({name, "_busy_c1"}, {31'd0, busy0}, 1);
      check({name, "_rd_c1"}, {30'd0, src_rd0, src_rd1}, 3);
      check({name, "_addr_c1"}, {15'd0, src_addr0}, 0);
      while (done0 !== 1'b1 && cyc < N + 20) begin
         if (cyc == restart_at) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      check({name, "_done_cycle"}, cyc, N + 4);
      check({name, "_done1"}, {31'd0, done1}, 1);
      cycles(4);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_busy_end"}, {30'd0, busy0, busy1}, 0);
      check({name, "_writes0"}, wcnt0, NPIX);
      check({name, "_writes1"}, wcnt1, NPIX);
      check({name, "_order"}, order_err, 0);
      for (int cy = 0; cy < L; cy++)
         for (int cx = 0; cx < W; cx++) begin
            check($sformatf("%s_g[%0d,%0d]", name, cx, cy), {16'd0, res0[cy * W + cx]}, {16'd0, ref_pix(cx, cy, 0)});
            check($sformatf("%s_t[%0d,%0d]", name, cx, cy), {16'd0, res1[cy * W + cx]}, {16'd0, ref_pix(cx, cy, THR1)});
         end
   endtask

   initial begin
      int wsave;
      rst   = 1'b1;
      start = 1'b0;
      cycles(3);
      check("rst_busy", {31'd0, busy0}, 0);
      check("rst_done", {31'd0, done0}, 0);
      check("rst_rd", {31'd0, src_rd0}, 0);
      check("rst_wr_en", {31'd0, wr_en0}, 0);
      check("rst_src_addr", {15'd0, src_addr0}, 0);
      check("rst_wr_addr", {15'd0, wr_addr0}, 0);
      check("rst_wr_data", {16'd0, wr_data0}, 0);
      rst = 1'b0;
      cycles(2);
      check("idle_busy", {31'd0, busy0}, 0);

      fill(1, 0);
      run_frame("flat", -1);
      fill(2, 0);
      run_frame("step", -1);
      check("step_sat", {16'd0, res0[3 * W + W / 2 - 1]}, 32'hFFFF);
      fill(3, 10);
      run_frame("imp10", -1);
      check("imp10_ring", {16'd0, res0[(L / 2) * W + W / 2 - 1]}, 32'h10A2);
      check("imp10_ctr", {16'd0, res0[(L / 2) * W + W / 2]}, 0);
      fill(3, 20);
      run_frame("imp20", -1);
      check("imp20_thr_ring", {16'd0, res1[(L / 2 - 1) * W + W / 2 + 1]}, 32'hFFFF);
      for (int k = 0; k < 3; k++) begin
         fill(0, 0);
         run_frame($sformatf("rand%0d", k), -1);
      end
      fill(0, 0);
      run_frame("restart", 50);

      // Reset in the middle of a frame must stop writes immediately.
      fill(0, 0);
      clear_capture();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cycles(60);
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en", {31'd0, wr_en0}, 0);
      check("mid_rst_busy", {31'd0, busy0}, 0);
      check("mid_rst_rd", {31'd0, src_rd0}, 0);
      wsave = wcnt0;
      cycles(3);
      rst = 1'b0;
      cycles(10);
      check("mid_rst_no_writes", wcnt0, wsave);
      check("mid_rst_no_done", done_cnt, 0);
      run_frame("after_rst", -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
